nios_sampler_led_sequencer: RTL

//  Autonomous pattern sequencer that drives the green-LED PIO write port (Avalon-MM master side).
//  The CPU loads a pattern table and step period through an Avalon-MM slave.
//  The block then replays the table to the PIO data register (PIO address 0) without CPU involvement.

---
 rtl/nios_sampler_led_sequencer_if.sv | 23 ++
 rtl/nios_sampler_led_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/nios_sampler_led_sequencer_if.sv
// Avalon-MM bundle for the LED sequencer: CPU-facing slave port plus the PIO master port.
// master = CPU/testbench side, slave = sequencer side.
interface nios_sampler_led_sequencer_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [2:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, pio_address, pio_chipselect, pio_write_n, pio_writedata
   );
endinterface

// File: rtl/nios_sampler_led_sequencer.sv
// Autonomous LED pattern sequencer: CPU loads a table and step period, the block replays
// it to the green-LED PIO data register; direct CPU LED writes pass through while idle.
module nios_sampler_led_sequencer #(
   parameter int NUM_STEPS = 8,
   parameter int LED_W     = 8,
   parameter int PERIOD_W  = 24
) (
   input  logic clk,
   input  logic reset_n,
   nios_sampler_led_sequencer_if.slave bus,
   output logic busy
);
   localparam int IW = $clog2(NUM_STEPS);
   localparam int LW = IW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
   state_t state, state_nxt;

   logic                            run, loop, drop_err;
   logic [PERIOD_W-1:0]             period, cnt, eff_period;
   logic [LW-1:0]                   length, eff_length, step_inc;
   logic [IW-1:0]                   index, step;
   logic [NUM_STEPS-1:0][LED_W-1:0] tbl;
   logic                            dir_vld;
   logic [LED_W-1:0]                dir_data, led_q, pat;
   logic                            wr, wr_ctrl, run_rise, run_stop, adv, last;
   logic                            unused;

   assign unused   = ^bus.writedata;
   assign wr       = bus.chipselect && !bus.write_n;
   assign wr_ctrl  = wr && (bus.address == 3'd0);
   assign run_rise = wr_ctrl && bus.writedata[0] && !run;
   assign run_stop = wr_ctrl && !bus.writedata[0];

   assign eff_period = (period == '0) ? PERIOD_W'(1) : period;
   assign eff_length = (length == '0 || length > LW'(NUM_STEPS)) ? LW'(NUM_STEPS) : length;
   assign step_inc   = {1'b0, step} + LW'(1);
   assign last       = step_inc >= eff_length;
   // A one-clock period skips WAIT entirely so steps land on consecutive cycles.
   assign adv = (state == LOAD && eff_period == PERIOD_W'(1)) ||
                (state == WAIT && cnt <= PERIOD_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (run_rise) state_nxt = LOAD;
         LOAD, WAIT: begin
            if (run_stop)  state_nxt = IDLE;
            else if (adv)  state_nxt = (last && !loop) ? IDLE : LOAD;
            else           state_nxt = WAIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      pat  = led_q;
      if (state == LOAD)  pat = tbl[step];
      else if (dir_vld)   pat = dir_data;
      bus.pio_chipselect = (state == LOAD) || dir_vld;
      bus.pio_write_n    = !bus.pio_chipselect;
      bus.pio_address    = 3'd0;
      bus.pio_writedata  = 32'(pat);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run      <= 1'b0;
         loop     <= 1'b0;
         drop_err <= 1'b0;
         period   <= '0;
         length   <= '0;
         index    <= '0;
         step     <= '0;
         cnt      <= '0;
         tbl      <= '0;
         dir_vld  <= 1'b0;
         dir_data <= '0;
         led_q    <= '0;
      end else begin
         if (wr_ctrl) begin
            run  <= bus.writedata[0];
            loop <= bus.writedata[1];
         end else if (busy && adv && last && !loop) begin
            run <= 1'b0;
         end

         if (state == IDLE) begin
            if (run_rise) step <= '0;
         end else if (adv && !run_stop) begin
            step <= last ? '0 : step + 1'b1;
         end

         // Counter loads only in LOAD, so PERIOD writes mid-WAIT wait for the next step.
         if (state == LOAD)                  cnt <= eff_period - PERIOD_W'(1);
         else if (state == WAIT && cnt != 0) cnt <= cnt - PERIOD_W'(1);

         if (wr && bus.address == 3'd1) period <= bus.writedata[PERIOD_W-1:0];
         if (wr && bus.address == 3'd2) length <= bus.writedata[LW-1:0];
         if (wr && bus.address == 3'd3 && bus.writedata[1]) drop_err <= 1'b0;
         if (wr && bus.address == 3'd4) index <= bus.writedata[IW-1:0];
         if (wr && bus.address == 3'd5) begin
            tbl[index] <= bus.writedata[LED_W-1:0];
            index      <= index + 1'b1;
         end

         dir_vld <= 1'b0;
         if (wr && bus.address == 3'd6) begin
            if (busy) begin
               drop_err <= 1'b1;
            end else begin
               dir_vld  <= 1'b1;
               dir_data <= bus.writedata[LED_W-1:0];
            end
         end

         if (bus.pio_chipselect) led_q <= pat;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         3'd0: bus.readdata = {30'd0, loop, run};
         3'd1: bus.readdata = 32'(period);
         3'd2: bus.readdata = 32'(length);
         3'd3: bus.readdata = 32'({4'(step), 2'b00, drop_err, busy});
         3'd4: bus.readdata = 32'(index);
         3'd5: bus.readdata = 32'(tbl[index]);
         default: bus.readdata = '0;
      endcase
   end
endmodule
